// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: PC sequencer feeding instr_mem, 2-entry {pc,instr} buffer toward decode
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int PC_STEP = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic             halt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic             fault,
  output logic [CNT_W-1:0] fetch_cnt
);
  typedef enum logic [1:0] {IDLE, FETCH, HALTED, FAULT} state_t;
  state_t state, state_nx;
  logic [31:0] pc, pc_nx, tail_pc, tail_instr;
  logic [1:0] cnt, cnt_nx;
  logic pop, push, redir_ok, redir_bad;
  assign imem_addr = pc;
  assign out_valid = cnt != 2'd0;
  always_comb begin
    pop = out_valid & out_ready;
    redir_ok = redirect_valid & (state != FAULT) & (redirect_pc[1:0] == 2'b00);
    redir_bad = redirect_valid & (state != FAULT) & (redirect_pc[1:0] != 2'b00);
    push = (state == FETCH) & ~redirect_valid & ~halt & ((cnt != 2'd2) | pop);
    state_nx = redir_bad ? FAULT :
               (redir_ok && state != IDLE) ? state :
               state == FAULT ? FAULT :
               halt ? HALTED : FETCH;
    pc_nx = redir_ok ? redirect_pc : push ? pc + 32'(PC_STEP) : pc;
    cnt_nx = (redir_ok | redir_bad) ? 2'd0 : cnt + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      cnt <= 2'd0;
      fault <= 1'b0;
      fetch_cnt <= '0;
      out_pc <= '0;
      out_instr <= '0;
      tail_pc <= '0;
      tail_instr <= '0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      cnt <= cnt_nx;
      fault <= fault | redir_bad;
      fetch_cnt <= fetch_cnt + CNT_W'(push);
      if (pop && cnt == 2'd2) begin
        out_pc <= tail_pc;
        out_instr <= tail_instr;
      end else if (push && (cnt == 2'd0 || pop)) begin
        out_pc <= pc;
        out_instr <= imem_rdata;
      end
      // the tail slot is written whenever the new word lands behind a surviving head
      if (push && (cnt == 2'd2 || (cnt == 2'd1 && !pop))) begin
        tail_pc <= pc;
        tail_instr <= imem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: directed scenarios plus randomized run against a queue-based model
module tb_instr_fetch_ctrl;
  logic clk = 0, rst = 1, redirect_valid = 0, halt = 0, out_ready = 0;
  logic [31:0] redirect_pc = 0, imem_addr, imem_rdata, out_instr, out_pc;
  logic out_valid, fault;
  logic [15:0] fetch_cnt;
  int checks = 0, errors = 0;
  int m_mode;
  logic [31:0] m_pc;
  logic [63:0] m_q[$];
  logic m_fault;
  logic [15:0] m_cnt;

  instr_fetch_ctrl dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .fault(fault), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  assign imem_rdata = mem(imem_addr);

  // modes: 0 idle, 1 fetching, 2 halted, 3 faulted
  task automatic step(input logic r, input logic rv, input logic [31:0] rpc, input logic h, input logic rdy);
    rst = r; redirect_valid = rv; redirect_pc = rpc; halt = h; out_ready = rdy;
    @(posedge clk);
    if (r) begin
      m_mode = 0; m_pc = 0; m_q.delete(); m_fault = 0; m_cnt = 0;
    end else begin
      if (m_q.size() != 0 && rdy) m_q.delete(0);
      if (rv && m_mode != 3) begin
        m_q.delete();
        if (rpc[1:0] == 2'b00) begin
          m_pc = rpc;
          if (m_mode == 0) m_mode = h ? 2 : 1;
        end else begin
          m_fault = 1; m_mode = 3;
        end
      end else if (m_mode == 0) m_mode = h ? 2 : 1;
      else if (m_mode == 1) begin
        if (h) m_mode = 2;
        else if (m_q.size() < 2) begin
          m_q.push_back({m_pc, mem(m_pc)});
          m_pc = m_pc + 4;
          m_cnt = m_cnt + 1;
        end
      end else if (m_mode == 2 && !h) m_mode = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", out_pc); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", out_instr); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", fault); end
    checks++; if (fetch_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got %0d want 0", fetch_cnt); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", imem_addr); end
  endtask

  task automatic test_stream();
    step(0, 0, 0, 0, 1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", out_valid); end
    for (int k = 0; k < 17; k++) begin
      step(0, 0, 0, 0, 1);
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== mem(32'(4 * k)))
        begin errors++; $display("FAIL stream_%0d got v=%b pc=%h i=%h want pc=%h", k, out_valid, out_pc, out_instr, 4 * k); end
      if (k == 14) begin
        checks++; if (fetch_cnt !== 16'd15) begin errors++; $display("FAIL stream_cnt got %0d want 15", fetch_cnt); end
      end
    end
  endtask

  task automatic test_backpressure();
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0);
    checks++; if (out_pc !== 32'h0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold got v=%b pc=%h want pc=0", out_valid, out_pc); end
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL bp_addr got %h want 8", imem_addr); end
    checks++; if (fetch_cnt !== 16'd2) begin errors++; $display("FAIL bp_cnt got %0d want 2", fetch_cnt); end
    for (int k = 1; k <= 3; k++) begin
      step(0, 0, 0, 0, 1);
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * k))
        begin errors++; $display("FAIL bp_release_%0d got v=%b pc=%h want %h", k, out_valid, out_pc, 4 * k); end
    end
  endtask

  task automatic test_redirect();
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    checks++; if (out_pc !== 32'h8 || m_q.size() != 2) begin errors++; $display("FAIL redir_setup got pc=%h want 8", out_pc); end
    step(0, 1, 32'h40, 0, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got %b want 0", out_valid); end
    step(0, 0, 0, 0, 1);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40) begin errors++; $display("FAIL redir_first got v=%b pc=%h want 40", out_valid, out_pc); end
    step(0, 0, 0, 0, 1);
    checks++; if (out_pc !== 32'h44 || out_instr !== mem(32'h44)) begin errors++; $display("FAIL redir_second got pc=%h want 44", out_pc); end
  endtask

  task automatic test_halt();
    logic [31:0] a;
    logic [15:0] c;
    a = imem_addr; c = fetch_cnt;
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 1, 1);
      checks++; if (imem_addr !== a || fetch_cnt !== c) begin errors++; $display("FAIL halt_hold_%0d got addr=%h cnt=%0d want %h %0d", k, imem_addr, fetch_cnt, a, c); end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL halt_drain got %b want 0", out_valid); end
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    checks++; if (out_valid !== 1'b1 || out_pc !== a) begin errors++; $display("FAIL halt_resume got v=%b pc=%h want %h", out_valid, out_pc, a); end
  endtask

  task automatic test_fault();
    logic [31:0] a;
    a = imem_addr;
    step(0, 1, 32'h42, 0, 1);
    checks++; if (fault !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL fault_set got f=%b v=%b want 1 0", fault, out_valid); end
    checks++; if (imem_addr !== a) begin errors++; $display("FAIL fault_pc got %h want %h", imem_addr, a); end
    step(0, 1, 32'h80, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    checks++; if (imem_addr !== a || out_valid !== 1'b0 || fault !== 1'b1)
      begin errors++; $display("FAIL fault_ignore got addr=%h v=%b f=%b want %h 0 1", imem_addr, out_valid, fault, a); end
    step(1, 0, 0, 0, 1);
    checks++; if (fault !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL fault_clear got f=%b addr=%h want 0 0", fault, imem_addr); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc[3];
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0;
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 1, 32'hFFFF_FFF8, 0, 1);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 1);
      checks++; if (out_valid !== 1'b1 || out_pc !== exp_pc[k] || out_instr !== mem(exp_pc[k]))
        begin errors++; $display("FAIL wrap_%0d got v=%b pc=%h want %h", k, out_valid, out_pc, exp_pc[k]); end
    end
    step(1, 0, 0, 0, 1);
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0 || fault !== 1'b0 || fetch_cnt !== 16'h0 || imem_addr !== 32'h0)
      begin errors++; $display("FAIL wrap_reset got v=%b pc=%h i=%h f=%b c=%0d a=%h want all 0", out_valid, out_pc, out_instr, fault, fetch_cnt, imem_addr); end
  endtask

  task automatic test_random();
    logic r, rv, h, rdy;
    logic [31:0] rpc;
    step(1, 0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      r = ($urandom % 80) == 0;
      rv = ($urandom % 12) == 0;
      rpc = $urandom;
      if (($urandom % 6) != 0) rpc[1:0] = 2'b00;
      h = ($urandom % 6) == 0;
      rdy = ($urandom % 3) != 0;
      step(r, rv, rpc, h, rdy);
      checks++; if (out_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rand_valid_%0d got %b want %b", n, out_valid, m_q.size() != 0); end
      if (m_q.size() != 0) begin
        checks++; if ({out_pc, out_instr} !== m_q[0]) begin errors++; $display("FAIL rand_head_%0d got %h_%h want %h", n, out_pc, out_instr, m_q[0]); end
      end
      checks++; if (imem_addr !== m_pc || fault !== m_fault || fetch_cnt !== m_cnt)
        begin errors++; $display("FAIL rand_state_%0d got a=%h f=%b c=%0d want %h %b %0d", n, imem_addr, fault, fetch_cnt, m_pc, m_fault, m_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_fault();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Fetch sequencer in front of instr_mem. Owns the PC, drives instr_mem's combinational read address, and captures each {pc, instruction} pair into a 2-entry output buffer with a valid/ready handshake toward decode. Handles redirects (branch/jump), halt/stall and misaligned-target faults, so decode never drives instr_mem directly.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
PC_STEP, 4, byte increment per sequential fetch
CNT_W, 16, width of fetch_cnt

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
imem_addr  output  32  byte address to instr_mem pc input (= pc register, combinational)
imem_rdata  input  32  instruction from instr_mem, valid same cycle as imem_addr
redirect_valid  input  1  load redirect_pc this cycle, flush buffer
redirect_pc  input  32  new fetch target (byte address)
halt  input  1  stop issuing new fetches while high
out_valid  output  1  buffer head holds a valid instruction
out_ready  input  1  decode accepts head this cycle
out_instr  output  32  head instruction
out_pc  output  32  PC of head instruction
fault  output  1  misaligned redirect seen; sticky until rst
fetch_cnt  output  CNT_W  instructions enqueued since reset, wraps

Behaviour:
- Reset (rst=1 at clk edge): pc=RESET_PC, state=IDLE, buffer count=0, out_valid=0, out_instr=0, out_pc=0, fault=0, fetch_cnt=0. rst overrides every other input, including mid-handshake.
- States: IDLE, FETCH, HALTED, FAULT.
  - IDLE: one cycle after reset, no enqueue; -> FETCH (-> HALTED if halt=1).
  - FETCH: enqueue when count<2, or count==2 with pop this cycle. On enqueue: buffer gets {pc, imem_rdata}, pc<=pc+PC_STEP (mod 2^32, 0xFFFFFFFC wraps to 0), fetch_cnt++. halt=1 -> HALTED, no enqueue that cycle.
  - HALTED: no enqueue, pc held, buffer still drains; halt=0 -> FETCH.
  - FAULT: no enqueue, no redirect accepted; buffer drains; exit only by rst.
- Pop: out_valid & out_ready. Head advances next cycle. out_instr/out_pc stable while out_valid=1 and out_ready=0.
- Buffer: 2-entry FIFO, registered outputs, order preserved. Simultaneous push+pop at count 2 keeps count 2: full throughput, one instruction per cycle, sustained.
- Latency: address presented in cycle N appears at out_* in cycle N+1 when the buffer was empty.
- Redirect (redirect_valid=1, state FETCH/HALTED/IDLE):
  - redirect_pc[1:0]==0: pc<=redirect_pc, count<=0 (out_valid=0 next cycle), no enqueue this cycle, state unchanged.
  - redirect_pc[1:0]!=0: fault<=1, state<=FAULT, count<=0, pc unchanged.
  - A pop in the same cycle as a redirect counts as accepted, then the buffer is flushed.
  - Redirect takes priority over halt and enqueue.
- imem_addr always equals the pc register, including in HALTED and FAULT.

Test Plan:
- Reset, out_ready=1, no halt -> out_pc sequence 0x0,0x4,0x8,..., one per cycle from cycle 2 after reset release; out_instr = instr_mem word; fetch_cnt=15 after 15 instructions.
- out_ready=0 for 5 cycles after first valid -> count saturates at 2, pc stops at 0x8, out_pc holds 0x0; release -> 0x0,0x4,0x8 delivered with no gap, nothing lost or duplicated.
- Redirect to 0x40 while buffer holds 0x8,0xC -> next cycle out_valid=0; following cycle out_pc=0x40, then 0x44.
- halt=1 for 3 cycles -> no enqueue, imem_addr constant; buffer drains; halt=0 -> fetching resumes at the held pc.
- Redirect to 0x42 -> fault=1, out_valid=0, later redirects to 0x80 ignored; rst -> fault=0, pc=RESET_PC.
- Redirect to 0xFFFFFFF8, ready=1 -> out_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; assert rst mid-stream -> every output at its reset value next cycle.
